// File: rtl/pc_datapath.sv
// Multi-cycle CPU PC/ALU datapath: operand muxes, ALU, next-PC select, PC/ALUOut/EPC registers.
// Latency: ALUResult/Zero/Overflow combinational; PC, ALUOut, OvfFlag, EPC update one clock after enable.
// Backpressure: none; the controller drives every enable directly each cycle and nothing stalls.
module pc_datapath (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        BranchNE,
  input  logic [1:0]  PCSource,
  input  logic [1:0]  ALUSrcA,
  input  logic [2:0]  ALUSrcB,
  input  logic [2:0]  ALUOp,
  input  logic        ALUOutWrite,
  input  logic        EPCWrite,
  input  logic [31:0] regA,
  input  logic [31:0] regB,
  input  logic [31:0] instr,
  output logic [31:0] PC,
  output logic [31:0] ALUOut,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        Overflow,
  output logic        OvfFlag,
  output logic [31:0] EPC
);

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] next_pc;
  logic        pc_load;
  logic        unused_instr_hi;

  // Opcode bits above the jump target are decoded by the controller, not here.
  assign unused_instr_hi = ^instr[31:26];

  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'd0, instr[15:0]};

  // Operand A select: PC, register A, or zero.
  always_comb begin
    op_a = 32'd0;
    case (ALUSrcA)
      2'd0:    op_a = PC;
      2'd1:    op_a = regA;
      default: op_a = 32'd0;
    endcase
  end

  // Operand B select: register B, +4, immediate variants, or zero.
  always_comb begin
    op_b = 32'd0;
    case (ALUSrcB)
      3'd0:    op_b = regB;
      3'd1:    op_b = 32'd4;
      3'd2:    op_b = imm_sext;
      3'd3:    op_b = {imm_sext[29:0], 2'b00};
      3'd4:    op_b = imm_zext;
      default: op_b = 32'd0;
    endcase
  end

  // ALU: result wraps modulo 2^32; overflow only meaningful for add/sub.
  always_comb begin
    ALUResult = 32'd0;
    Overflow  = 1'b0;
    case (ALUOp)
      3'd0: ALUResult = op_a;
      3'd1: begin
        ALUResult = op_a + op_b;
        Overflow  = (op_a[31] == op_b[31]) && (ALUResult[31] != op_a[31]);
      end
      3'd2: begin
        ALUResult = op_a - op_b;
        Overflow  = (op_a[31] != op_b[31]) && (ALUResult[31] != op_a[31]);
      end
      3'd3: ALUResult = op_a & op_b;
      3'd4: ALUResult = op_a | op_b;
      3'd5: ALUResult = op_a ^ op_b;
      3'd6: ALUResult = ~op_a;
      default: ALUResult = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
    endcase
  end

  assign Zero = (ALUResult == 32'd0);

  // Next-PC select: ALU result, registered ALUOut, jump target, or exception vector.
  always_comb begin
    next_pc = ALUResult;
    case (PCSource)
      2'd0: next_pc = ALUResult;
      2'd1: next_pc = ALUOut;
      2'd2: next_pc = {PC[31:28], instr[25:0], 2'b00};
      2'd3: next_pc = EXC_VECTOR;
      default: next_pc = ALUResult;
    endcase
  end

  // PCWrite alone forces the load; the branch term only adds loads on top of it.
  assign pc_load = PCWrite | (PCWriteCond & (Zero ^ BranchNE));

  // Architectural registers; reset overrides every enable, and all loads see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      PC      <= 32'd0;
      ALUOut  <= 32'd0;
      OvfFlag <= 1'b0;
      EPC     <= 32'd0;
    end else begin
      if (pc_load)     PC <= next_pc;
      if (ALUOutWrite) begin
        ALUOut  <= ALUResult;
        OvfFlag <= Overflow;
      end
      if (EPCWrite)    EPC <= ALUResult;
    end
  end

endmodule

// File: tb/tb_pc_datapath.sv
// Directed testbench for pc_datapath with hand-computed expected values.
// Inputs change 1 time unit after the rising edge; outputs are sampled away from the edge.
// All comparisons funnel through one checking task that counts and reports.
module tb_pc_datapath;

  logic        clock;
  logic        reset;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        BranchNE;
  logic [1:0]  PCSource;
  logic [1:0]  ALUSrcA;
  logic [2:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic        ALUOutWrite;
  logic        EPCWrite;
  logic [31:0] regA;
  logic [31:0] regB;
  logic [31:0] instr;
  logic [31:0] PC;
  logic [31:0] ALUOut;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Overflow;
  logic        OvfFlag;
  logic [31:0] EPC;

  int checks;
  int failures;

  pc_datapath dut (
    .clock       (clock),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .BranchNE    (BranchNE),
    .PCSource    (PCSource),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .ALUOutWrite (ALUOutWrite),
    .EPCWrite    (EPCWrite),
    .regA        (regA),
    .regB        (regB),
    .instr       (instr),
    .PC          (PC),
    .ALUOut      (ALUOut),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .Overflow    (Overflow),
    .OvfFlag     (OvfFlag),
    .EPC         (EPC)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    PCWrite = 0; PCWriteCond = 0; BranchNE = 0; PCSource = 0;
    ALUSrcA = 0; ALUSrcB = 0; ALUOp = 0; ALUOutWrite = 0; EPCWrite = 0;
  endtask

  // Load PC with an arbitrary value routed through regA + 0.
  task automatic load_pc(input logic [31:0] val);
    idle();
    regA = val; ALUSrcA = 1; ALUSrcB = 5; ALUOp = 1; PCSource = 0; PCWrite = 1;
    tick();
    idle();
  endtask

  initial begin
    checks = 0; failures = 0;
    idle();
    reset = 1; regA = 0; regB = 0; instr = 0;

    // Reset state
    tick();
    tick();
    check("rst_pc", PC, 32'd0);
    check("rst_aluout", ALUOut, 32'd0);
    check("rst_epc", EPC, 32'd0);
    check("rst_ovf", OvfFlag, 1'b0);
    check("rst_zero", Zero, 1'b1);

    // Fetch: PC += 4 three times
    reset = 0;
    ALUSrcA = 0; ALUSrcB = 1; ALUOp = 1; PCSource = 0; PCWrite = 1;
    tick(); check("fetch_pc1", PC, 32'd4);
    tick(); check("fetch_pc2", PC, 32'd8);
    tick(); check("fetch_pc3", PC, 32'd12);
    check("fetch_alures", ALUResult, 32'd16);
    idle();

    // Immediate extension variants (operand A forced to zero)
    instr = 32'h0000_FFFC; ALUSrcA = 2; ALUOp = 1;
    ALUSrcB = 2; #1 check("imm_sext", ALUResult, 32'hFFFF_FFFC);
    ALUSrcB = 3; #1 check("imm_sext_sl2", ALUResult, 32'hFFFF_FFF0);
    ALUSrcB = 4; #1 check("imm_zext", ALUResult, 32'h0000_FFFC);
    ALUSrcB = 7; #1 check("opb_zero", ALUResult, 32'd0);
    idle();

    // Branch taken (BEQ with equal operands)
    load_pc(32'h100);
    check("br_pc_init", PC, 32'h100);
    instr = 32'h0000_0003; ALUSrcA = 0; ALUSrcB = 3; ALUOp = 1; ALUOutWrite = 1;
    #1 check("br_target_comb", ALUResult, 32'h10C);
    tick();
    check("br_aluout", ALUOut, 32'h10C);
    check("br_pc_hold", PC, 32'h100);
    idle();
    regA = 5; regB = 5; ALUSrcA = 1; ALUSrcB = 0; ALUOp = 2; PCSource = 1; PCWriteCond = 1;
    #1 check("br_zero", Zero, 1'b1);
    tick();
    check("br_taken_pc", PC, 32'h10C);

    // Branch with BranchNE=1 and equal operands: not taken
    load_pc(32'h100);
    regA = 5; regB = 5; ALUSrcA = 1; ALUSrcB = 0; ALUOp = 2; PCSource = 1;
    PCWriteCond = 1; BranchNE = 1;
    tick();
    check("bne_not_taken_pc", PC, 32'h100);
    // BranchNE=1 with unequal operands: taken
    regB = 6;
    tick();
    check("bne_taken_pc", PC, 32'h10C);
    idle();

    // Jump
    load_pc(32'h4000_0010);
    instr = 32'h0800_0040; PCSource = 2; PCWrite = 1;
    tick();
    check("jump_pc", PC, 32'h4000_0100);
    idle();

    // Add overflow
    regA = 32'h7FFF_FFFF; regB = 1; ALUSrcA = 1; ALUSrcB = 0; ALUOp = 1; ALUOutWrite = 1;
    #1 check("add_ovf_comb", Overflow, 1'b1);
    tick();
    check("add_ovf_aluout", ALUOut, 32'h8000_0000);
    check("add_ovf_flag", OvfFlag, 1'b1);
    ALUOutWrite = 0; ALUOp = 3;
    #1 check("and_no_ovf", Overflow, 1'b0);
    check("and_result", ALUResult, 32'd1);
    tick();
    check("ovf_flag_hold", OvfFlag, 1'b1);

    // Sub overflow, logic ops and signed compare
    regA = 32'h8000_0000; regB = 1; ALUOp = 2;
    #1 check("sub_ovf_comb", Overflow, 1'b1);
    check("sub_wrap", ALUResult, 32'h7FFF_FFFF);
    regA = 32'hF0F0_00FF; regB = 32'h0FF0_0F0F;
    ALUOp = 4; #1 check("or_result", ALUResult, 32'hFFF0_0FFF);
    ALUOp = 5; #1 check("xor_result", ALUResult, 32'hFF00_0FF0);
    ALUOp = 6; #1 check("not_result", ALUResult, 32'h0F0F_FF00);
    regA = 32'hFFFF_FFFF; regB = 1;
    ALUOp = 7; #1 check("slt_neg", ALUResult, 32'd1);
    check("slt_no_ovf", Overflow, 1'b0);
    regA = 1; regB = 32'hFFFF_FFFF;
    #1 check("slt_pos", ALUResult, 32'd0);
    idle();

    // Exception entry: EPC = PC - 4, PC = vector, same cycle
    load_pc(32'h20);
    ALUSrcA = 0; ALUSrcB = 1; ALUOp = 2; EPCWrite = 1; PCSource = 3; PCWrite = 1;
    tick();
    check("exc_epc", EPC, 32'h1C);
    check("exc_pc", PC, 32'h8000_0180);
    idle();

    // Simultaneous loads sample pre-edge values: PC takes old ALUOut
    load_pc(32'h0);
    regA = 32'h7FFF_FFFF; ALUSrcA = 1; ALUSrcB = 1; ALUOp = 1;
    ALUOutWrite = 1; PCSource = 1; PCWrite = 1;
    tick();
    check("simul_pc_old_aluout", PC, 32'h8000_0000);
    check("simul_aluout_new", ALUOut, 32'h8000_0003);
    check("simul_ovf_set", OvfFlag, 1'b1);
    idle();

    // Reset asserted between edges leaves registers alone until the edge
    PCWrite = 1; ALUOutWrite = 1; EPCWrite = 1;
    ALUSrcA = 1; regA = 32'h7FFF_FFFF; ALUSrcB = 1; ALUOp = 1;
    reset = 1;
    #2 check("midcycle_pc_hold", PC, 32'h8000_0000);
    check("midcycle_epc_hold", EPC, 32'h1C);
    tick();
    // Reset overrides all enables
    check("rstpri_pc", PC, 32'd0);
    check("rstpri_aluout", ALUOut, 32'd0);
    check("rstpri_epc", EPC, 32'd0);
    check("rstpri_ovf", OvfFlag, 1'b0);
    idle();
    reset = 0;
    #1 check("post_rst_alures", ALUResult, 32'd0);
    check("post_rst_zero", Zero, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
